ps2_key_controller: RTL and testbench
=====================================

# ps2_key_controller

Sequences the raw PS/2 keyboard bus into per-player button vectors for the tank game. The block has three stages: a bit-level frame receiver with parity, stop and timeout checking; a scan-code prefix decoder that tracks make, break and extended sequences; and a per-player arbiter. The arbiter turns any set of held keys into one one-hot command per player. It sits between the board PS/2 pins and the two tank movement/fire controllers.

## Interface
- TIMEOUT_CYCLES, 50000: clk_50m cycles allowed between kclk falling edges inside a frame (1 ms at 50 MHz).
- clk_50m  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- kclk  in  1  raw PS/2 clock pin, asynchronous.
- kdata  in  1  raw PS/2 data pin, asynchronous.
- player1_btns  out  5  one-hot {FIRE,RIGHT,LEFT,DOWN,UP} for player 1; all zero when no key is held.
- player2_btns  out  5  same encoding for player 2.
- frame_err  out  1  one-cycle pulse on a parity, stop-bit or timeout error.

## Operation
- **Synchronizers:** kclk and kdata each pass through 2 flops; reset value 1.
- **Edge detect:** a falling edge is synchronized kclk at 0 with its previous value at 1. kdata is sampled in the same cycle.
- **Frame FSM states:** IDLE, DATA, PARITY, STOP.
  - IDLE: an edge with kdata=0 goes to DATA and clears the bit count. An edge with kdata=1 is ignored.
  - DATA: shift kdata in LSB first; after 8 edges go to PARITY.
  - PARITY: store the bit, go to STOP.
  - STOP: parity is correct when the 8 data bits plus the parity bit hold an odd number of ones.
    - Stop bit 1 and parity correct: pulse byte_valid (internal) and go to IDLE.
    - Otherwise: pulse frame_err, discard the byte, go to IDLE.
- **Timeout:** the counter clears on every edge and on IDLE. In any non-IDLE state, reaching TIMEOUT_CYCLES-1 sends the FSM to IDLE, pulses frame_err and resets the decoder to D_IDLE.
- **Decoder FSM states:** D_IDLE, D_EXT, D_BREAK, D_EXT_BREAK. It acts only on byte_valid.
  - Byte E0: from D_IDLE go to D_EXT.
  - Byte F0: from D_IDLE go to D_BREAK; from D_EXT go to D_EXT_BREAK.
  - Any other byte in D_IDLE: make.
  - Any other byte in D_BREAK: break.
  - Any other byte in D_EXT or D_EXT_BREAK: ignored, because extended keys are unmapped.
  - Every non-prefix byte returns the FSM to D_IDLE.
  - E0 or F0 arriving in a state not listed above returns the FSM to D_IDLE with no effect.
- **Key map (code -> player, bit):**
  - Player 1: 1D UP0, 1B DOWN1, 1C LEFT2, 23 RIGHT3, 29 FIRE4.
  - Player 2: 43 UP0, 42 DOWN1, 3B LEFT2, 4B RIGHT3, 5A FIRE4.
  - Unmapped codes change nothing.
- **Held state:** 10-bit held register. A make sets the bit; a typematic repeat make is idempotent. A break clears the bit.
- **Per-player arbiter:**
  - A make records its bit index as `last` for that player.
  - If `last`'s key is still held, the output is one-hot(`last`).
  - Otherwise the output is the lowest-index held bit (UP highest priority).
  - With nothing held, the output is 0.
- **Player independence:** the two players never affect each other.

## Timing
- **Reset:** all outputs 0. FSMs in IDLE/D_IDLE, held=0, `last` invalid, counters 0. Reset asserted mid-frame discards the partial frame.
- **Latency:** let edge detection of the stop-bit edge be cycle N.
  - byte_valid is high in N+1.
  - held and `last` update at the end of N+1.
  - player*_btns change in N+2. Outputs are registered.
- **Error pulse:** frame_err is high exactly in cycle N+1 of the failing edge, or in the cycle after the timeout count is reached.
- **Simultaneous events:** only one byte is decoded per frame, so make and break never collide. Timeout and an edge in the same cycle: the edge wins and the counter clears.
- **Bus rate:** kclk edges are at least 30 µs apart, so each edge is seen exactly once.

## Test plan
- **Single make:** frame for 1D with good parity -> player1_btns=00001 two cycles after the stop edge; player2_btns=0; frame_err never pulses.
- **Last pressed wins:** make 1D, then make 29 -> 10000. Break 29 (F0,29) -> falls back to 00001. Break 1D -> 00000.
- **Two players:** make 43 and 1C interleaved -> p1=00100, p2=00001 at the same time. Break F0 43 -> p2=0, p1 unchanged.
- **Frame errors:**
  - 1D with a wrong parity bit -> frame_err one cycle, outputs unchanged.
  - Stop bit 0 -> same.
  - Extended E0,1D -> no change.
  - E0,F0,1D after a 1D make -> 1D stays held.
- **Timeout:**
  - Send F0, then only 4 bits of the next frame and stall for 50000 cycles -> frame_err pulse, decoder back to D_IDLE.
  - A following 1D frame is then treated as a make, not a break.
- **Reset during a held key:** assert rst with p1=01000 -> all outputs 0 immediately. After release, a break for 23 leaves outputs at 0.

Source files
------------

// File: rtl/ps2_key_controller.sv
// PS/2 keyboard front end for the tank game: frame receiver, scan-code prefix
// decoder and per-player one-hot button arbiter.
module ps2_key_controller #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic       kclk,
  input  logic       kdata,
  output logic [4:0] player1_btns,
  output logic [4:0] player2_btns,
  output logic       frame_err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  localparam logic [1:0] D_IDLE      = 2'd0;
  localparam logic [1:0] D_EXT       = 2'd1;
  localparam logic [1:0] D_BREAK     = 2'd2;
  localparam logic [1:0] D_EXT_BREAK = 2'd3;

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic          kclk_s1, kclk_s2, kclk_prev, kdata_s1, kdata_s2;
  logic          kclk_fall;
  logic [1:0]    rx_state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_bit;
  logic [CW-1:0] to_cnt;
  logic          byte_valid;
  logic          timeout_hit;

  logic [1:0]    dstate, dstate_next;
  logic [9:0]    held, held_next;
  logic          last1_v, last1_v_next, last2_v, last2_v_next;
  logic [2:0]    last1, last1_next, last2, last2_next;
  logic          make_ev, brk_ev;
  logic [4:0]    key;

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      kclk_s1   <= 1'b1;
      kclk_s2   <= 1'b1;
      kclk_prev <= 1'b1;
      kdata_s1  <= 1'b1;
      kdata_s2  <= 1'b1;
    end else begin
      kclk_s1   <= kclk;
      kclk_s2   <= kclk_s1;
      kclk_prev <= kclk_s2;
      kdata_s1  <= kdata;
      kdata_s2  <= kdata_s1;
    end
  end

  assign kclk_fall = kclk_prev & ~kclk_s2;

  // An edge always restarts the timeout count, so a late edge beats the timeout.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      rx_state    <= IDLE;
      bit_cnt     <= 3'd0;
      shift       <= 8'd0;
      par_bit     <= 1'b0;
      to_cnt      <= '0;
      byte_valid  <= 1'b0;
      frame_err   <= 1'b0;
      timeout_hit <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      frame_err   <= 1'b0;
      timeout_hit <= 1'b0;
      if (kclk_fall) begin
        to_cnt <= '0;
        case (rx_state)
          IDLE: begin
            if (!kdata_s2) begin
              rx_state <= DATA;
              bit_cnt  <= 3'd0;
            end
          end
          DATA: begin
            shift   <= {kdata_s2, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) rx_state <= PARITY;
          end
          PARITY: begin
            par_bit  <= kdata_s2;
            rx_state <= STOP;
          end
          default: begin
            rx_state <= IDLE;
            if (kdata_s2 && (^{shift, par_bit})) byte_valid <= 1'b1;
            else frame_err <= 1'b1;
          end
        endcase
      end else if (rx_state == IDLE) begin
        to_cnt <= '0;
      end else if (to_cnt == TO_LAST) begin
        rx_state    <= IDLE;
        to_cnt      <= '0;
        frame_err   <= 1'b1;
        timeout_hit <= 1'b1;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  // Returns {valid, index}; indices 0-4 belong to player 1, 5-9 to player 2.
  function automatic logic [4:0] map_key(input logic [7:0] code);
    case (code)
      8'h1D:   return {1'b1, 4'd0};
      8'h1B:   return {1'b1, 4'd1};
      8'h1C:   return {1'b1, 4'd2};
      8'h23:   return {1'b1, 4'd3};
      8'h29:   return {1'b1, 4'd4};
      8'h43:   return {1'b1, 4'd5};
      8'h42:   return {1'b1, 4'd6};
      8'h3B:   return {1'b1, 4'd7};
      8'h4B:   return {1'b1, 4'd8};
      8'h5A:   return {1'b1, 4'd9};
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [4:0] arbitrate(input logic [4:0] h, input logic lv,
                                           input logic [2:0] li);
    logic [4:0] r;
    r = 5'd0;
    if (lv && h[li]) begin
      r[li] = 1'b1;
    end else begin
      for (int i = 4; i >= 0; i--)
        if (h[i]) r = 5'b00001 << i;
    end
    return r;
  endfunction

  always_comb begin
    dstate_next = dstate;
    make_ev     = 1'b0;
    brk_ev      = 1'b0;
    if (timeout_hit) begin
      dstate_next = D_IDLE;
    end else if (byte_valid) begin
      if (shift == 8'hE0) begin
        dstate_next = (dstate == D_IDLE) ? D_EXT : D_IDLE;
      end else if (shift == 8'hF0) begin
        case (dstate)
          D_IDLE:  dstate_next = D_BREAK;
          D_EXT:   dstate_next = D_EXT_BREAK;
          default: dstate_next = D_IDLE;
        endcase
      end else begin
        make_ev     = (dstate == D_IDLE);
        brk_ev      = (dstate == D_BREAK);
        dstate_next = D_IDLE;
      end
    end
  end

  // Outputs are computed from the next held/last values so they register one
  // cycle after byte_valid rather than two.
  always_comb begin
    key          = map_key(shift);
    held_next    = held;
    last1_v_next = last1_v;
    last1_next   = last1;
    last2_v_next = last2_v;
    last2_next   = last2;
    if (key[4] && make_ev) begin
      held_next[key[3:0]] = 1'b1;
      if (key[3:0] < 4'd5) begin
        last1_v_next = 1'b1;
        last1_next   = key[2:0];
      end else begin
        last2_v_next = 1'b1;
        last2_next   = 3'(key[3:0] - 4'd5);
      end
    end
    if (key[4] && brk_ev) held_next[key[3:0]] = 1'b0;
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      dstate       <= D_IDLE;
      held         <= 10'd0;
      last1_v      <= 1'b0;
      last1        <= 3'd0;
      last2_v      <= 1'b0;
      last2        <= 3'd0;
      player1_btns <= 5'd0;
      player2_btns <= 5'd0;
    end else begin
      dstate       <= dstate_next;
      held         <= held_next;
      last1_v      <= last1_v_next;
      last1        <= last1_next;
      last2_v      <= last2_v_next;
      last2        <= last2_next;
      player1_btns <= arbitrate(held_next[4:0], last1_v_next, last1_next);
      player2_btns <= arbitrate(held_next[9:5], last2_v_next, last2_next);
    end
  end

endmodule

// File: tb/tb_ps2_key_controller.sv
// Self-checking bench for ps2_key_controller: directed vector table, hand
// sequences for timeout and reset, then random frames against a key model.
module tb_ps2_key_controller;

  localparam int TO = 1000;

  logic       clk_50m = 1'b0;
  logic       rst;
  logic       kclk;
  logic       kdata;
  logic [4:0] player1_btns;
  logic [4:0] player2_btns;
  logic       frame_err;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [4:0] cap_p1 [6];
  logic [4:0] cap_p2 [6];
  logic [5:0] cap_err;

  bit m_held [10];
  int m_last [2];
  bit m_ext, m_brk;

  typedef struct {
    logic [7:0] data;
    logic       bad_par;
    logic       bad_stop;
    logic [4:0] p1;
    logic [4:0] p2;
  } vec_t;

  vec_t tbl [28];

  always #10 clk_50m = ~clk_50m;

  ps2_key_controller #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_50m      (clk_50m),
    .rst          (rst),
    .kclk         (kclk),
    .kdata        (kdata),
    .player1_btns (player1_btns),
    .player2_btns (player2_btns),
    .frame_err    (frame_err)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Bits are presented 8 clocks before each falling kclk edge.
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      kdata = bits[i];
      repeat (8) @(negedge clk_50m);
      kclk = 1'b0;
      repeat (8) @(negedge clk_50m);
      kclk = 1'b1;
    end
  endtask

  // Full frame; captures outputs on the 6 cycles after the stop-bit edge.
  task automatic applyStimulus(input logic [7:0] data, input logic bad_par,
                               input logic bad_stop);
    logic [10:0] bits;
    bits = {~bad_stop, (~^data) ^ bad_par, data, 1'b0};
    send_bits(bits, 10);
    kdata = bits[10];
    repeat (8) @(negedge clk_50m);
    kclk = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_50m);
      cap_p1[k]  = player1_btns;
      cap_p2[k]  = player2_btns;
      cap_err[k] = frame_err;
    end
    repeat (4) @(negedge clk_50m);
    kclk  = 1'b1;
    kdata = 1'b1;
    repeat (8) @(negedge clk_50m);
  endtask

  // Old value up to N+1, new value from N+2, error only in N+1.
  task automatic check_frame(input string name, input logic [4:0] old1,
                             input logic [4:0] old2, input logic [4:0] new1,
                             input logic [4:0] new2, input logic err);
    checkOutput({name, "_p1_before"}, 32'(cap_p1[2]), 32'(old1));
    checkOutput({name, "_p2_before"}, 32'(cap_p2[2]), 32'(old2));
    checkOutput({name, "_p1_after"},  32'(cap_p1[3]), 32'(new1));
    checkOutput({name, "_p2_after"},  32'(cap_p2[3]), 32'(new2));
    checkOutput({name, "_err"}, 32'(cap_err), err ? 32'h04 : 32'h00);
  endtask

  function automatic int key_index(input logic [7:0] c);
    case (c)
      8'h1D: return 0;  8'h1B: return 1;  8'h1C: return 2;
      8'h23: return 3;  8'h29: return 4;  8'h43: return 5;
      8'h42: return 6;  8'h3B: return 7;  8'h4B: return 8;
      8'h5A: return 9;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    foreach (m_held[i]) m_held[i] = 1'b0;
    m_last[0] = -1;
    m_last[1] = -1;
    m_ext = 1'b0;
    m_brk = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] c);
    int k;
    if (c == 8'hE0) begin
      if (!m_ext && !m_brk) m_ext = 1'b1;
      else begin m_ext = 1'b0; m_brk = 1'b0; end
    end else if (c == 8'hF0) begin
      if (!m_brk) m_brk = 1'b1;
      else begin m_ext = 1'b0; m_brk = 1'b0; end
    end else begin
      k = key_index(c);
      if (!m_ext && k >= 0) begin
        if (m_brk) m_held[k] = 1'b0;
        else begin m_held[k] = 1'b1; m_last[k / 5] = k; end
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  function automatic logic [4:0] model_out(input int p);
    if (m_last[p] >= 0 && m_held[m_last[p]]) return 5'b00001 << (m_last[p] - 5 * p);
    for (int i = 0; i < 5; i++)
      if (m_held[5 * p + i]) return 5'b00001 << i;
    return 5'b00000;
  endfunction

  initial begin
    logic [7:0]  pool [14];
    logic [7:0]  code;
    logic        bad;
    logic [4:0]  o1, o2;
    logic [4:0]  prev1, prev2;
    int          err_cnt;

    tbl[0]  = '{8'h1D, 1'b0, 1'b0, 5'b00001, 5'b00000};
    tbl[1]  = '{8'h29, 1'b0, 1'b0, 5'b10000, 5'b00000};
    tbl[2]  = '{8'hF0, 1'b0, 1'b0, 5'b10000, 5'b00000};
    tbl[3]  = '{8'h29, 1'b0, 1'b0, 5'b00001, 5'b00000};
    tbl[4]  = '{8'hF0, 1'b0, 1'b0, 5'b00001, 5'b00000};
    tbl[5]  = '{8'h1D, 1'b0, 1'b0, 5'b00000, 5'b00000};
    tbl[6]  = '{8'h43, 1'b0, 1'b0, 5'b00000, 5'b00001};
    tbl[7]  = '{8'h1C, 1'b0, 1'b0, 5'b00100, 5'b00001};
    tbl[8]  = '{8'hF0, 1'b0, 1'b0, 5'b00100, 5'b00001};
    tbl[9]  = '{8'h43, 1'b0, 1'b0, 5'b00100, 5'b00000};
    tbl[10] = '{8'hF0, 1'b0, 1'b0, 5'b00100, 5'b00000};
    tbl[11] = '{8'h1C, 1'b0, 1'b0, 5'b00000, 5'b00000};
    tbl[12] = '{8'h1D, 1'b1, 1'b0, 5'b00000, 5'b00000};
    tbl[13] = '{8'h1D, 1'b0, 1'b1, 5'b00000, 5'b00000};
    tbl[14] = '{8'hE0, 1'b0, 1'b0, 5'b00000, 5'b00000};
    tbl[15] = '{8'h1D, 1'b0, 1'b0, 5'b00000, 5'b00000};
    tbl[16] = '{8'h1D, 1'b0, 1'b0, 5'b00001, 5'b00000};
    tbl[17] = '{8'hE0, 1'b0, 1'b0, 5'b00001, 5'b00000};
    tbl[18] = '{8'hF0, 1'b0, 1'b0, 5'b00001, 5'b00000};
    tbl[19] = '{8'h1D, 1'b0, 1'b0, 5'b00001, 5'b00000};
    tbl[20] = '{8'h23, 1'b0, 1'b0, 5'b01000, 5'b00000};
    tbl[21] = '{8'h1B, 1'b0, 1'b0, 5'b00010, 5'b00000};
    tbl[22] = '{8'hF0, 1'b0, 1'b0, 5'b00010, 5'b00000};
    tbl[23] = '{8'h1B, 1'b0, 1'b0, 5'b00001, 5'b00000};
    tbl[24] = '{8'hF0, 1'b0, 1'b0, 5'b00001, 5'b00000};
    tbl[25] = '{8'h1D, 1'b0, 1'b0, 5'b01000, 5'b00000};
    tbl[26] = '{8'hF0, 1'b0, 1'b0, 5'b01000, 5'b00000};
    tbl[27] = '{8'h23, 1'b0, 1'b0, 5'b00000, 5'b00000};

    pool = '{8'hE0, 8'hF0, 8'hF0, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29,
             8'h43, 8'h42, 8'h3B, 8'h4B, 8'h5A, 8'h15};

    rst   = 1'b1;
    kclk  = 1'b1;
    kdata = 1'b1;
    repeat (4) @(negedge clk_50m);
    checkOutput("reset_p1", 32'(player1_btns), 32'h0);
    checkOutput("reset_p2", 32'(player2_btns), 32'h0);
    checkOutput("reset_err", 32'(frame_err), 32'h0);
    rst = 1'b0;
    repeat (8) @(negedge clk_50m);

    prev1 = 5'd0;
    prev2 = 5'd0;
    for (int i = 0; i < 28; i++) begin
      applyStimulus(tbl[i].data, tbl[i].bad_par, tbl[i].bad_stop);
      check_frame($sformatf("vec%0d", i), prev1, prev2, tbl[i].p1, tbl[i].p2,
                  tbl[i].bad_par | tbl[i].bad_stop);
      prev1 = tbl[i].p1;
      prev2 = tbl[i].p2;
    end

    // Timeout after a break prefix must clear the prefix.
    applyStimulus(8'h1D, 1'b0, 1'b0);
    check_frame("to_make", 5'd0, 5'd0, 5'b00001, 5'd0, 1'b0);
    applyStimulus(8'hF0, 1'b0, 1'b0);
    check_frame("to_prefix", 5'b00001, 5'd0, 5'b00001, 5'd0, 1'b0);
    send_bits({1'b1, 1'b1, 8'h1D, 1'b0}, 4);
    err_cnt = 0;
    for (int c = 0; c < TO + 100; c++) begin
      @(negedge clk_50m);
      if (frame_err) err_cnt++;
    end
    checkOutput("to_err_pulses", 32'(err_cnt), 32'd1);
    checkOutput("to_p1_hold", 32'(player1_btns), 32'b00001);
    applyStimulus(8'h1D, 1'b0, 1'b0);
    check_frame("to_after", 5'b00001, 5'd0, 5'b00001, 5'd0, 1'b0);

    // Reset with a key held and a partial frame in flight.
    applyStimulus(8'h23, 1'b0, 1'b0);
    check_frame("rst_make", 5'b00001, 5'd0, 5'b01000, 5'd0, 1'b0);
    send_bits({1'b1, 1'b0, 8'h1B, 1'b0}, 5);
    kclk = 1'b0;
    repeat (3) @(negedge clk_50m);
    rst = 1'b1;
    #1;
    checkOutput("rst_async_p1", 32'(player1_btns), 32'h0);
    checkOutput("rst_async_p2", 32'(player2_btns), 32'h0);
    repeat (3) @(negedge clk_50m);
    kclk  = 1'b1;
    kdata = 1'b1;
    rst   = 1'b0;
    repeat (20) @(negedge clk_50m);
    applyStimulus(8'hF0, 1'b0, 1'b0);
    check_frame("rst_f0", 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    applyStimulus(8'h23, 1'b0, 1'b0);
    check_frame("rst_break", 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    applyStimulus(8'h1D, 1'b0, 1'b0);
    check_frame("rst_remake", 5'd0, 5'd0, 5'b00001, 5'd0, 1'b0);

    // Random frames against the behavioural model.
    @(negedge clk_50m);
    rst = 1'b1;
    repeat (3) @(negedge clk_50m);
    rst = 1'b0;
    model_reset();
    repeat (8) @(negedge clk_50m);
    for (int i = 0; i < 80; i++) begin
      code = pool[$urandom_range(0, 13)];
      bad  = ($urandom_range(0, 9) == 0);
      o1   = model_out(0);
      o2   = model_out(1);
      applyStimulus(code, bad, 1'b0);
      if (!bad) model_byte(code);
      check_frame($sformatf("rnd%0d_%02h", i, code), o1, o2, model_out(0),
                  model_out(1), bad);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
